// File: rtl/spi_master_ctrl_if.sv
// Host-side command/read-back bundle for spi_master_ctrl.
// master = host/test sequencer side, slave = controller side.
interface spi_master_ctrl_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [FRAME_W-1:0] cmd_data;
  logic               busy;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, busy, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, busy, rd_valid, rd_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Master-side driver for the 10-bit SPI slave frame protocol, one bit per clk.
// Sends a command frame on MOSI and, for rd-data opcodes, captures DATA_W bits from MISO.
module spi_master_ctrl #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int GAP_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_ctrl_if.slave     host,
  input  logic                 MISO,
  output logic                 SS_n,
  output logic                 MOSI
);

  localparam int CNT_W = $clog2(FRAME_W + DATA_W + 16);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
  localparam logic [CNT_W-1:0] LAST_CAPT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    PAD   = 3'd2,
    SHIFT = 3'd3,
    WAIT  = 3'd4,
    CAPT  = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               is_rd, is_rd_d;
  logic [FRAME_W-1:0] sreg, sreg_d;
  logic [DATA_W-1:0]  cap, cap_d;

  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    is_rd_d    = is_rd;
    sreg_d     = sreg;
    cap_d      = cap;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    case (state)
      IDLE: begin
        if (host.cmd_valid && ready_q) begin
          sreg_d  = host.cmd_data;
          is_rd_d = (host.cmd_data[FRAME_W-1 -: 2] == 2'b11);
          ss_n_d  = 1'b0;
          mosi_d  = host.cmd_data[FRAME_W-1];
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = CMD;
        end
      end

      // The slave reads the first MOSI bit as its write/read select.
      CMD: begin
        mosi_d  = sreg[FRAME_W-1];
        state_d = PAD;
      end

      PAD: begin
        mosi_d  = sreg[FRAME_W-1];
        cnt_d   = '0;
        state_d = SHIFT;
      end

      // PAD already put the MSB out, so SHIFT emits bit FRAME_W-2 downwards
      // and uses its final count to close the frame.
      SHIFT: begin
        if (cnt == LAST_SHIFT) begin
          mosi_d = 1'b0;
          cnt_d  = '0;
          if (is_rd) begin
            state_d = (RD_WAIT == 0) ? CAPT : WAIT;
          end else begin
            ss_n_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          mosi_d = sreg[FRAME_W-2];
          sreg_d = sreg << 1;
          cnt_d  = cnt + 1'b1;
        end
      end

      WAIT: begin
        if (cnt == LAST_WAIT) begin
          cnt_d   = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      CAPT: begin
        cap_d = {cap[DATA_W-2:0], MISO};
        if (cnt == LAST_CAPT) begin
          rd_data_d  = {cap[DATA_W-2:0], MISO};
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
          cnt_d      = '0;
          state_d    = GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      GAP: begin
        if (cnt == LAST_GAP) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; shift/capture registers carry no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      is_rd      <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      is_rd      <= is_rd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
    sreg <= sreg_d;
    cap  <= cap_d;
  end

  assign SS_n           = ss_n_q;
  assign MOSI           = mosi_q;
  assign host.cmd_ready = ready_q;
  assign host.busy      = busy_q;
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: per-cycle capture of the SPI pins and
// host signals, then checks against hand-computed frame expectations.
module tb_spi_master_ctrl;

  localparam int GAP_CYC = 1;
  localparam int NOBS    = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic MISO;
  logic SS_n;
  logic MOSI;

  spi_master_ctrl_if #(.FRAME_W(10), .DATA_W(8)) host_if ();

  spi_master_ctrl #(.FRAME_W(10), .DATA_W(8), .RD_WAIT(2), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host_if),
    .MISO  (MISO),
    .SS_n  (SS_n),
    .MOSI  (MOSI)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic       ss  [NOBS];
  logic       mo  [NOBS];
  logic       rv  [NOBS];
  logic       rdy [NOBS];
  logic       bsy [NOBS];
  logic [7:0] rd  [NOBS];

  int         ev_cyc [3];
  logic       ev_vld [3];
  logic [9:0] ev_dat [3];
  int         rst_c;
  logic       miso_en;
  logic [7:0] miso_byte;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_knobs();
    for (int i = 0; i < 3; i++) begin
      ev_cyc[i] = -1;
      ev_vld[i] = 1'b0;
      ev_dat[i] = '0;
    end
    rst_c   = -1;
    miso_en = 1'b0;
  endtask

  task automatic set_ev(input int i, input int c, input logic v, input logic [9:0] d);
    ev_cyc[i] = c;
    ev_vld[i] = v;
    ev_dat[i] = d;
  endtask

  task automatic start(input logic [9:0] cmd);
    int t;
    t = 0;
    @(negedge clk);
    while (host_if.cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    host_if.cmd_data  = cmd;
    host_if.cmd_valid = 1'b1;
    MISO              = 1'b1;
  endtask

  // Index c holds the values seen after edge Ec; E0 is the first edge after start.
  task automatic observe(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      ss[c]  = SS_n;
      mo[c]  = MOSI;
      rv[c]  = host_if.rd_valid;
      rdy[c] = host_if.cmd_ready;
      bsy[c] = host_if.busy;
      rd[c]  = host_if.rd_data;
      if (rst_c >= 0 && c == rst_c)     rst_n = 1'b0;
      if (rst_c >= 0 && c == rst_c + 1) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (ev_cyc[i] == c) begin
          host_if.cmd_valid = ev_vld[i];
          host_if.cmd_data  = ev_dat[i];
        end
      end
      if (miso_en && c >= 14 && c < 22) MISO = miso_byte[21 - c];
      else                              MISO = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int b, input int len,
                             input logic [11:0] emo, input logic erv, input logic [7:0] erd);
    int         low;
    int         pulses;
    logic [11:0] mo12;
    low = 0;
    while (b + low < NOBS && ss[b + low] === 1'b0) low++;
    chk({tag, ".len"}, low, len);
    for (int i = 0; i < 12; i++) mo12[11 - i] = mo[b + i];
    chk({tag, ".mosi"}, 32'(mo12), 32'(emo));
    chk({tag, ".mosi_end"}, 32'(mo[b + 12]), 0);
    pulses = 0;
    for (int c = b; c <= b + len + 2; c++) pulses += (rv[c] === 1'b1) ? 1 : 0;
    chk({tag, ".pulses"}, pulses, erv ? 1 : 0);
    if (erv) begin
      chk({tag, ".rv_edge"}, 32'(rv[b + len]), 1);
      chk({tag, ".rd_data"}, 32'(rd[b + len]), 32'(erd));
      chk({tag, ".rd_hold"}, 32'(rd[b + len + 2]), 32'(erd));
    end
    chk({tag, ".rdy_gap"},  32'(rdy[b + len + GAP_CYC - 1]), 0);
    chk({tag, ".rdy_back"}, 32'(rdy[b + len + GAP_CYC]), 1);
    chk({tag, ".bsy_gap"},  32'(bsy[b + len + GAP_CYC - 1]), 1);
    chk({tag, ".bsy_end"},  32'(bsy[b + len + GAP_CYC]), 0);
  endtask

  function automatic int lows(input int from, input int to);
    int k;
    k = 0;
    for (int c = from; c < to; c++) k += (ss[c] === 1'b0) ? 1 : 0;
    return k;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    clr_knobs();
    rst_n             = 1'b0;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_data  = '0;
    MISO              = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ss_n",  32'(SS_n), 1);
    chk("rst.mosi",  32'(MOSI), 0);
    chk("rst.ready", 32'(host_if.cmd_ready), 1);
    chk("rst.busy",  32'(host_if.busy), 0);
    chk("rst.rv",    32'(host_if.rd_valid), 0);
    chk("rst.rd",    32'(host_if.rd_data), 0);
    rst_n = 1'b1;

    // wr-addr frame
    clr_knobs();
    start(10'b00_1010_0101);
    set_ev(0, 0, 1'b0, 10'b00_1010_0101);
    observe(30);
    check_frame("t1", 0, 12, 12'h0A5, 1'b0, 8'h00);

    // rd-addr frame: no capture phase
    clr_knobs();
    start(10'b10_0000_0111);
    set_ev(0, 0, 1'b0, 10'b10_0000_0111);
    observe(30);
    check_frame("t3", 0, 12, 12'hE07, 1'b0, 8'h00);
    chk("t3.extra_low", lows(12, 30), 0);

    // reset in the middle of a rd-data frame
    clr_knobs();
    start(10'b11_0101_0101);
    set_ev(0, 0, 1'b0, 10'b11_0101_0101);
    rst_c     = 5;
    miso_en   = 1'b1;
    miso_byte = 8'hA5;
    observe(30);
    chk("t5.pre_ss",   32'(ss[5]), 0);
    chk("t5.ss_n",     32'(ss[6]), 1);
    chk("t5.mosi",     32'(mo[6]), 0);
    chk("t5.rv",       32'(rv[6]), 0);
    chk("t5.rd",       32'(rd[6]), 0);
    chk("t5.ready",    32'(rdy[6]), 1);
    chk("t5.busy",     32'(bsy[6]), 0);
    chk("t5.no_frame", lows(6, 30), 0);
    chk("t5.rd_later", 32'(rd[29]), 0);

    // rd-data frame, slave returns 0xC3
    clr_knobs();
    start(10'b11_0000_0000);
    set_ev(0, 0, 1'b0, 10'b11_0000_0000);
    miso_en   = 1'b1;
    miso_byte = 8'hC3;
    observe(30);
    check_frame("t2", 0, 22, 12'hF00, 1'b1, 8'hC3);

    // cmd_valid held with a second command queued behind the first
    clr_knobs();
    start(10'b01_1100_1010);
    set_ev(0, 0,  1'b1, 10'b10_0110_0011);
    set_ev(1, 14, 1'b0, 10'b10_0110_0011);
    observe(40);
    check_frame("t4a", 0, 12, 12'h1CA, 1'b0, 8'h00);
    hi = 0;
    while (12 + hi < 40 && ss[12 + hi] === 1'b1) hi++;
    chk("t4.gap", hi, 2);
    check_frame("t4b", 14, 12, 12'hE63, 1'b0, 8'h00);
    chk("t4.extra_low", lows(26, 40), 0);

    // cmd_data change and a cmd_valid pulse while busy are ignored
    clr_knobs();
    start(10'b00_0011_1100);
    set_ev(0, 0, 1'b0, 10'b00_0011_1100);
    set_ev(1, 5, 1'b1, 10'b11_1111_1111);
    set_ev(2, 6, 1'b0, 10'b11_1111_1111);
    observe(30);
    check_frame("t6", 0, 12, 12'h03C, 1'b0, 8'h00);
    chk("t6.extra_low", lows(12, 30), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
